// File: rtl/uart_pkg.sv
// Shared UART types and constants.
//   DATA_W            width of one UART data byte
//   frame_type_t      frame type encoding shared with uart_tnsm
//   parity_type_t     parity type encoding shared with uart_tnsm
//   stop_type_t       stop type encoding shared with uart_tnsm
//   tx_sched_state_e  states of the transmit scheduler
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [1:0] frame_type_t;
  typedef logic [1:0] parity_type_t;
  typedef logic       stop_type_t;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT,
    RELEASE
  } tx_sched_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or after rr_ptr, wrapping modulo NUM_REQ.
//   req     in   NUM_REQ  level requests
//   rr_ptr  in   PTR_W    highest-priority requester index (must be < NUM_REQ)
//   pick    out  NUM_REQ  one-hot winner, all zero when req is zero
module uart_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] pick_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_pick;

  // Rotate so rr_ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    // NOTE: every variable gets a value before any conditional logic so no latch is inferred.
    rot_pick = '0;
    req_dbl  = {req, req} >> rr_ptr;
    rot_req  = req_dbl[NUM_REQ-1:0];
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        rot_pick    = '0;
        rot_pick[i] = 1'b1;
      end
    end
    pick_dbl = {{NUM_REQ{1'b0}}, rot_pick} << rr_ptr;
    pick     = pick_dbl[2*NUM_REQ-1:NUM_REQ] | pick_dbl[NUM_REQ-1:0];
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tnsm transmitter among NUM_REQ requesters.
// Optional launch watchdog: define UART_TX_SCHED_TIMEOUT_EN.
//   clk, rst                      system clock, synchronous active-high reset
//   enable                        when low, no new grants are issued
//   req / req_data                level requests and their bytes (byte i on [8i+7:8i])
//   cfg_frame/parity/stop_type    frame config, sampled at grant
//   gnt / done                    one-hot grant (grant to frame end), one-cycle completion
//   err                           one-cycle watchdog abort pulse (timeout build only)
//   tnsm_clk_en, tx_busy          baud tick and busy from uart_tnsm
//   tx_active, tx_tnsm, tx_clr    control to uart_tnsm
//   tx_data, tx_*_type            latched byte and frame config to uart_tnsm
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*8-1:0]    req_data,
  input  frame_type_t             cfg_frame_type,
  input  parity_type_t            cfg_parity_type,
  input  stop_type_t              cfg_stop_type,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  input  logic                    tnsm_clk_en,
  input  logic                    tx_busy,
  output logic                    tx_active,
  output logic                    tx_tnsm,
  output logic [DATA_W-1:0]       tx_data,
  output frame_type_t             tx_frame_type,
  output parity_type_t            tx_parity_type,
  output stop_type_t              tx_stop_type,
  output logic                    tx_clr
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  tx_sched_state_e   state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [DATA_W-1:0] data_q, data_d;
  frame_type_t       frame_q, frame_d;
  parity_type_t      parity_q, parity_d;
  stop_type_t        stop_q, stop_d;

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  pick_data;
  logic               timeout;
  logic               unused_in;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PTR_W'(i);
        pick_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent waiting on uart_tnsm; cleared in every other state.
  always_comb begin
    cnt_d = (state_q == LAUNCH || state_q == WAIT) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout   = (state_q == LAUNCH || state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign unused_in = tnsm_clk_en;
`else
  assign timeout   = 1'b0;
  assign unused_in = tnsm_clk_en | (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    frame_d  = frame_q;
    parity_d = parity_q;
    stop_d   = stop_q;
    unique case (state_q)
      IDLE: begin
        // tx_busy high here means someone else owns the transmitter; hold off.
        if (enable && (|req) && !tx_busy) begin
          state_d  = GRANT;
          owner_d  = pick_idx;
          data_d   = pick_data;
          frame_d  = cfg_frame_type;
          parity_d = cfg_parity_type;
          stop_d   = cfg_stop_type;
        end
      end
      // tx_tnsm is held low here so uart_tnsm always sees a fresh rising edge.
      GRANT:   state_d = LAUNCH;
      LAUNCH:  if (timeout) state_d = RELEASE;
               else if (tx_busy) state_d = WAIT;
      WAIT:    if (timeout || !tx_busy) state_d = RELEASE;
      RELEASE: begin
        state_d  = IDLE;
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      frame_q  <= '0;
      parity_q <= '0;
      stop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      frame_q  <= frame_d;
      parity_q <= parity_d;
      stop_q   <= stop_d;
    end
  end

  // gnt covers GRANT..WAIT; it drops in RELEASE, the cycle done pulses.
  always_comb begin
    gnt  = '0;
    done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        gnt[i]  = (state_q == GRANT) || (state_q == LAUNCH) || (state_q == WAIT);
        done[i] = (state_q == RELEASE);
      end
    end
  end

  assign tx_tnsm        = (state_q == LAUNCH) && !timeout;
  assign tx_active      = enable | (state_q != IDLE);
  assign err            = timeout;
  assign tx_clr         = timeout;
  assign tx_data        = data_q;
  assign tx_frame_type  = frame_q;
  assign tx_parity_type = parity_q;
  assign tx_stop_type   = stop_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a small uart_tnsm busy model and
// a scoreboard of expected grants (requester index, byte, frame config).
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  frame_type_t          cfg_frame_type;
  parity_type_t         cfg_parity_type;
  stop_type_t           cfg_stop_type;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic                 tnsm_clk_en;
  logic                 tx_busy;
  logic                 tx_active;
  logic                 tx_tnsm;
  logic [7:0]           tx_data;
  frame_type_t          tx_frame_type;
  parity_type_t         tx_parity_type;
  stop_type_t           tx_stop_type;
  logic                 tx_clr;

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .req             (req),
    .req_data        (req_data),
    .cfg_frame_type  (cfg_frame_type),
    .cfg_parity_type (cfg_parity_type),
    .cfg_stop_type   (cfg_stop_type),
    .gnt             (gnt),
    .done            (done),
    .err             (err),
    .tnsm_clk_en     (tnsm_clk_en),
    .tx_busy         (tx_busy),
    .tx_active       (tx_active),
    .tx_tnsm         (tx_tnsm),
    .tx_data         (tx_data),
    .tx_frame_type   (tx_frame_type),
    .tx_parity_type  (tx_parity_type),
    .tx_stop_type    (tx_stop_type),
    .tx_clr          (tx_clr)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [1:0] ft;
    logic [1:0] pt;
    logic       st;
  } exp_t;

  exp_t exp_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int gnt_seen  = 0;
  int done_seen = 0;

  // uart_tnsm stand-in: busy for busy_len cycles after seeing tx_tnsm.
  bit               model_en   = 1'b1;
  bit               busy_force = 1'b0;
  int               busy_len   = 5;
  int               busy_cnt   = 0;
  logic [NUM_REQ-1:0] hold_mask = '0;

  // 8N1 as this bench encodes it.
  localparam logic [1:0] FT_8N1 = 2'b11;
  localparam logic [1:0] PT_8N1 = 2'b00;
  localparam logic       ST_8N1 = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
      end else if (busy_force) begin
        tx_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end else if (model_en && tx_tnsm) begin
        tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Clients drop their request once granted, unless told to hold it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      req = req & ~(gnt & ~hold_mask);
    end
  end

  // Scoreboard monitor: grant rise peeks the head, done pops it.
  initial begin
    logic [NUM_REQ-1:0] prev_gnt;
    logic [NUM_REQ-1:0] oh;
    exp_t e;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (gnt != '0 && prev_gnt == '0) begin
        gnt_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL gnt_unexpected: gnt=%b, required no grant", gnt);
        end else begin
          oh = 4'b0001 << exp_q[0].idx;
          if (gnt !== oh || tx_data !== exp_q[0].data ||
              tx_frame_type !== exp_q[0].ft || tx_parity_type !== exp_q[0].pt ||
              tx_stop_type !== exp_q[0].st) begin
            n_fail++;
            $display("FAIL gnt_order: gnt=%b data=%h cfg=%b/%b/%b, required gnt=%b data=%h cfg=%b/%b/%b",
                     gnt, tx_data, tx_frame_type, tx_parity_type, tx_stop_type,
                     oh, exp_q[0].data, exp_q[0].ft, exp_q[0].pt, exp_q[0].st);
          end
        end
      end
      if (done != '0) begin
        done_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: done=%b, required no done", done);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e.idx;
          if (done !== oh || gnt !== '0 || tx_data !== e.data ||
              tx_frame_type !== e.ft || tx_parity_type !== e.pt || tx_stop_type !== e.st) begin
            n_fail++;
            $display("FAIL done_order: done=%b gnt=%b data=%h cfg=%b/%b/%b, required done=%b gnt=0 data=%h cfg=%b/%b/%b",
                     done, gnt, tx_data, tx_frame_type, tx_parity_type, tx_stop_type,
                     oh, e.data, e.ft, e.pt, e.st);
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.ft   = FT_8N1;
    e.pt   = PT_8N1;
    e.st   = ST_8N1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req       = '0;
    hold_mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (done_seen < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (done_seen < target) begin
      n_fail++;
      $display("FAIL %s: done count %0d, required %0d within %0d cycles", name, done_seen, target, budget);
    end
  endtask

  task automatic wait_gnts(input int target, input int budget);
    int c;
    c = 0;
    while (gnt_seen < target && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    enable          = 1'b0;
    req             = '0;
    req_data        = '0;
    cfg_frame_type  = FT_8N1;
    cfg_parity_type = PT_8N1;
    cfg_stop_type   = ST_8N1;
    tnsm_clk_en     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (gnt !== '0 || done !== '0) begin
      n_fail++;
      $display("FAIL reset_gnt_done: gnt=%b done=%b, required 0/0", gnt, done);
    end
    n_checks++;
    if (tx_tnsm !== 1'b0 || tx_active !== 1'b0 || err !== 1'b0 || tx_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: tnsm=%b active=%b err=%b clr=%b, required all 0",
               tx_tnsm, tx_active, err, tx_clr);
    end
    n_checks++;
    if (tx_data !== 8'h00 || tx_frame_type !== 2'b00 || tx_parity_type !== 2'b00 || tx_stop_type !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h cfg=%b/%b/%b, required all 0",
               tx_data, tx_frame_type, tx_parity_type, tx_stop_type);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c;
    @(negedge clk);
    enable        = 1'b1;
    req_data[7:0] = 8'hA5;
    push(0, 8'hA5);
    req = 4'b0001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || tx_tnsm !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt_latency: gnt=%b tnsm=%b, required 0001/0", gnt, tx_tnsm);
    end
    @(negedge clk);
    cfg_frame_type  = 2'b01;
    cfg_parity_type = 2'b10;
    cfg_stop_type   = 1'b1;
    tick();
    n_checks++;
    if (tx_tnsm !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_tnsm_rise: tnsm=%b data=%h, required 1/a5", tx_tnsm, tx_data);
    end
    c = 0;
    while (tx_busy !== 1'b1 && c < 20) begin tick(); c++; end
    while (tx_busy !== 1'b0 && c < 40) begin tick(); c++; end
    tick();
    n_checks++;
    if (done !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_done_after_busy: done=%b, required 0001", done);
    end
    @(negedge clk);
    cfg_frame_type  = FT_8N1;
    cfg_parity_type = PT_8N1;
    cfg_stop_type   = ST_8N1;
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    @(negedge clk);
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    base = done_seen;
    push(0, 8'h11);
    push(1, 8'h22);
    push(3, 8'h44);
    req = 4'b1011;
    wait_dones(base + 3, 200, "rr_three_frames");
    // rr_ptr must have wrapped to 0, so 0 wins over 1.
    @(negedge clk);
    push(0, 8'h11);
    push(1, 8'h22);
    req = 4'b0011;
    wait_dones(base + 5, 200, "rr_wrap_frames");
  endtask

  task automatic test_fairness();
    int base;
    int base_g;
    @(negedge clk);
    req_data[23:16] = 8'h5C;
    req_data[7:0]   = 8'hC3;
    base   = done_seen;
    base_g = gnt_seen;
    push(2, 8'h5C);
    hold_mask = 4'b0100;
    req[2]    = 1'b1;
    wait_gnts(base_g + 1, 50);
    push(0, 8'hC3);
    push(2, 8'h5C);
    req[0] = 1'b1;
    wait_gnts(base_g + 3, 200);
    hold_mask = '0;
    req[2]    = 1'b0;
    wait_dones(base + 3, 200, "fair_frames");
  endtask

  task automatic test_enable();
    int base;
    int c;
    int bad;
    @(negedge clk);
    busy_len      = 20;
    req_data[7:0] = 8'h3C;
    base = done_seen;
    push(0, 8'h3C);
    req = 4'b0001;
    c = 0;
    while (tx_busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    @(negedge clk);
    enable          = 1'b0;
    req_data[15:8]  = 8'h96;
    req[1]          = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_active !== 1'b1 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL enable_mid_frame: active=%b gnt=%b, required 1/0001", tx_active, gnt);
    end
    wait_dones(base + 1, 100, "enable_frame_finishes");
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_active !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_active_idle: active=%b, required 0", tx_active);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL enable_no_grant: %0d cycles with grant, required 0", bad);
    end
    push(1, 8'h96);
    enable = 1'b1;
    wait_dones(base + 2, 100, "enable_resume");
    busy_len = 5;
  endtask

  task automatic test_reset_mid_frame();
    int c;
    @(negedge clk);
    busy_len         = 30;
    req_data[31:24]  = 8'hE7;
    push(3, 8'hE7);
    req = 4'b1000;
    c = 0;
    while (tx_busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++;
    if (gnt !== '0 || done !== '0 || tx_tnsm !== 1'b0 || tx_clr !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_frame: gnt=%b done=%b tnsm=%b clr=%b data=%h, required 0/0/0/0/00",
               gnt, done, tx_tnsm, tx_clr, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    void'(exp_q.pop_front());
    busy_len = 5;
  endtask

  task automatic test_busy_foreign();
    int base;
    int bad;
    @(negedge clk);
    busy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_data[15:8] = 8'h6B;
    base = done_seen;
    push(1, 8'h6B);
    req = 4'b0010;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_foreign_hold: %0d cycles with grant, required 0", bad);
    end
    busy_force = 1'b0;
    wait_dones(base + 1, 100, "busy_foreign_release");
  endtask

  task automatic test_timeout();
    int c;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    int k_hit;
    @(negedge clk);
    model_en      = 1'b0;
    req_data[7:0] = 8'hD2;
    push(0, 8'hD2);
    req = 4'b0001;
    c = 0;
    while (tx_tnsm !== 1'b1 && c < 10) begin tick(); c++; end
    k_hit = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (tx_clr === 1'b1) begin
        k_hit = k;
        break;
      end
    end
    n_checks++;
    if (k_hit != TIMEOUT || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_cycles: clr after %0d cycles err=%b, required %0d/1", k_hit, err, TIMEOUT);
    end
    tick();
    n_checks++;
    if (tx_clr !== 1'b0 || err !== 1'b0 || done !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout_release: clr=%b err=%b done=%b, required 0/0/0001", tx_clr, err, done);
    end
    model_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
`else
    @(negedge clk);
    model_en      = 1'b0;
    req_data[7:0] = 8'hD2;
    push(0, 8'hD2);
    req = 4'b0001;
    c = 0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (tx_tnsm !== 1'b1 || err !== 1'b0 || tx_clr !== 1'b0 || done !== '0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL no_timeout_stall: tnsm=%b err=%b clr=%b done=%b gnt=%b, required 1/0/0/0000/0001",
               tx_tnsm, err, tx_clr, done, gnt);
    end
    do_reset();
    void'(exp_q.pop_front());
    model_en = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_enable();
    test_reset_mid_frame();
    test_busy_foreign();
    test_timeout();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
